// File: rtl/rv_main_ctrl.sv
// rtl/rv_main_ctrl.sv - RV32I single-cycle control unit (main decoder + ALU decoder)
//
// Purpose:
//   Decodes opcode, funct3, funct7[5] and the ALU Zero flag into the datapath
//   controls of a single-cycle RV32I core. All decode outputs are purely
//   combinational; clk/rst only clock the optional sticky illegal-opcode flag.
//
// Optional feature macro: CTRL_ILLEGAL_OP_EN
//   Defined   -> adds registered output IllegalOp (sticky until rst).
//   Undefined -> no IllegalOp port; clk and rst are unused.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset (registered state only)
//   op         in   7  instr[6:0]
//   funct3     in   3  instr[14:12]
//   funct7     in   1  instr[30] (funct7 bit 5)
//   Zero       in   1  ALU result-equals-zero flag
//   PCSrc      out  1  1 = PC+imm, 0 = PC+4
//   MemWrite   out  1  data memory write enable
//   ALUSrc     out  1  1 = immediate operand B, 0 = rs2
//   RegWrite   out  1  register file write enable
//   ImmSrc     out  2  00 I, 01 S, 10 B, 11 J
//   ResultSrc  out  2  00 ALU, 01 memory, 10 PC+4
//   ALUControl out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//   IllegalOp  out  1  (CTRL_ILLEGAL_OP_EN only) sticky illegal-opcode flag

module rv_main_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic       PCSrc,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl
`ifdef CTRL_ILLEGAL_OP_EN
  ,
  output logic       IllegalOp
`endif
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic       branch;
  logic       jump;
  logic [1:0] alu_op;
  logic       legal_op;
  logic       rtype_sub;

  // Main decoder: unknown opcodes fall through to an all-zero decode so an
  // illegal instruction can never write state or redirect the PC.
  always_comb begin
    RegWrite  = 1'b0;
    ImmSrc    = 2'b00;
    ALUSrc    = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = 2'b00;
    branch    = 1'b0;
    alu_op    = 2'b00;
    jump      = 1'b0;
    legal_op  = 1'b1;
    case (op)
      OP_LW: begin
        RegWrite  = 1'b1;
        ALUSrc    = 1'b1;
        ResultSrc = 2'b01;
      end
      OP_SW: begin
        ImmSrc   = 2'b01;
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      OP_R: begin
        RegWrite = 1'b1;
        alu_op   = 2'b10;
      end
      OP_I: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        alu_op   = 2'b10;
      end
      OP_BEQ: begin
        ImmSrc = 2'b10;
        branch = 1'b1;
        alu_op = 2'b01;
      end
      OP_JAL: begin
        RegWrite  = 1'b1;
        ImmSrc    = 2'b11;
        ResultSrc = 2'b10;
        jump      = 1'b1;
      end
      default: legal_op = 1'b0;
    endcase
  end

  assign PCSrc = (branch & Zero) | jump;

  // op[5] separates R-type from I-type: addi has no sub form, so funct7 is
  // ignored there (it is part of the immediate).
  assign rtype_sub = op[5] & funct7;

  // ALU decoder.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = rtype_sub ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b100:  ALUControl = 3'b100;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

`ifdef CTRL_ILLEGAL_OP_EN
  logic illegal_q;
  logic illegal_d;

  assign illegal_d = illegal_q | ~legal_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign IllegalOp = illegal_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, legal_op};
`endif

endmodule

// File: tb/tb_rv_main_ctrl.sv
// tb/tb_rv_main_ctrl.sv - self-checking bench for rv_main_ctrl
module tb_rv_main_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0000000;
  logic [2:0] funct3 = 3'b000;
  logic       funct7 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCSrc, MemWrite, ALUSrc, RegWrite;
  logic [1:0] ImmSrc, ResultSrc;
  logic [2:0] ALUControl;
`ifdef CTRL_ILLEGAL_OP_EN
  logic       IllegalOp;
  logic       exp_ill = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;
  bit run_cmp = 1'b0;

  rv_main_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .PCSrc(PCSrc), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUControl(ALUControl)
`ifdef CTRL_ILLEGAL_OP_EN
    , .IllegalOp(IllegalOp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] imm;
    logic       asrc;
    logic       mw;
    logic [1:0] res;
    logic       pc;
    logic [2:0] alu;
  } exp_t;

  // ALU function named by funct3 for the arithmetic instruction classes.
  function automatic logic [2:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
  endfunction

  // Expected controls per instruction class.
  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3,
                                 input logic f7, input logic z);
    exp_t e;
    e = '0;
    if (o == 7'b0000011) begin        // lw
      e.rw = 1; e.asrc = 1; e.res = 2'b01;
    end else if (o == 7'b0100011) begin // sw
      e.imm = 2'b01; e.asrc = 1; e.mw = 1;
    end else if (o == 7'b0110011) begin // R-type
      e.rw = 1;
      e.alu = (f3 == 3'd0) ? (f7 ? 3'd1 : 3'd0) : f3_alu(f3);
    end else if (o == 7'b0010011) begin // I-type ALU
      e.rw = 1; e.asrc = 1;
      e.alu = f3_alu(f3);
    end else if (o == 7'b1100011) begin // beq
      e.imm = 2'b10; e.alu = 3'd1; e.pc = z;
    end else if (o == 7'b1101111) begin // jal
      e.rw = 1; e.imm = 2'b11; e.res = 2'b10; e.pc = 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s op=%b f3=%b f7=%b z=%b actual=%0h expected=%0h",
               name, op, funct3, funct7, Zero, act, exp);
    end
  endtask

  // Model-based compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      exp_t e;
      e = model(op, funct3, funct7, Zero);
      chk("RegWrite",   {3'b0, RegWrite},   {3'b0, e.rw});
      chk("ImmSrc",     {2'b0, ImmSrc},     {2'b0, e.imm});
      chk("ALUSrc",     {3'b0, ALUSrc},     {3'b0, e.asrc});
      chk("MemWrite",   {3'b0, MemWrite},   {3'b0, e.mw});
      chk("ResultSrc",  {2'b0, ResultSrc},  {2'b0, e.res});
      chk("PCSrc",      {3'b0, PCSrc},      {3'b0, e.pc});
      chk("ALUControl", {1'b0, ALUControl}, {1'b0, e.alu});
`ifdef CTRL_ILLEGAL_OP_EN
      chk("IllegalOp",  {3'b0, IllegalOp},  {3'b0, exp_ill});
`endif
    end
  end

`ifdef CTRL_ILLEGAL_OP_EN
  always @(posedge clk) begin
    if (rst) exp_ill <= 1'b0;
    else if (!is_legal(op)) exp_ill <= 1'b1;
  end
`endif

  task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    @(posedge clk);
    #1;
    op = o; funct3 = f3; funct7 = f7; Zero = z;
    #1;
  endtask

  initial begin
    // Reset state: op=0 is illegal and decodes to all zeros.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_RegWrite", {3'b0, RegWrite}, 4'd0);
    chk("rst_PCSrc",    {3'b0, PCSrc},    4'd0);
    chk("rst_MemWrite", {3'b0, MemWrite}, 4'd0);
`ifdef CTRL_ILLEGAL_OP_EN
    chk("rst_IllegalOp", {3'b0, IllegalOp}, 4'd0);
`endif
    op = 7'b0000011;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cmp = 1'b1;

    // Hand-computed expectations.
    apply(7'b0000011, 3'b010, 1'b0, 1'b0);
    chk("lw_RegWrite", {3'b0, RegWrite}, 4'd1);
    chk("lw_ResultSrc", {2'b0, ResultSrc}, 4'd1);
    chk("lw_ALUSrc", {3'b0, ALUSrc}, 4'd1);
    apply(7'b0100011, 3'b010, 1'b0, 1'b0);
    chk("sw_MemWrite", {3'b0, MemWrite}, 4'd1);
    chk("sw_ImmSrc", {2'b0, ImmSrc}, 4'd1);
    chk("sw_RegWrite", {3'b0, RegWrite}, 4'd0);
    apply(7'b0010011, 3'b000, 1'b1, 1'b0);
    chk("addi_ALUControl", {1'b0, ALUControl}, 4'd0);
    chk("addi_ALUSrc", {3'b0, ALUSrc}, 4'd1);
    apply(7'b0110011, 3'b000, 1'b1, 1'b0);
    chk("sub_ALUControl", {1'b0, ALUControl}, 4'd1);
    chk("sub_ALUSrc", {3'b0, ALUSrc}, 4'd0);
    apply(7'b1101111, 3'b000, 1'b0, 1'b0);
    chk("jal_PCSrc", {3'b0, PCSrc}, 4'd1);
    chk("jal_ImmSrc", {2'b0, ImmSrc}, 4'd3);
    chk("jal_ResultSrc", {2'b0, ResultSrc}, 4'd2);
    apply(7'b1100011, 3'b000, 1'b0, 1'b1);
    chk("beq_taken", {3'b0, PCSrc}, 4'd1);
    chk("beq_ALUControl", {1'b0, ALUControl}, 4'd1);
    chk("beq_ImmSrc", {2'b0, ImmSrc}, 4'd2);
    apply(7'b1100011, 3'b000, 1'b0, 1'b0);
    chk("beq_not_taken", {3'b0, PCSrc}, 4'd0);
    apply(7'b0110011, 3'b111, 1'b0, 1'b0);
    chk("and_ALUControl", {1'b0, ALUControl}, 4'd2);
    apply(7'b0110011, 3'b110, 1'b0, 1'b0);
    chk("or_ALUControl", {1'b0, ALUControl}, 4'd3);
    apply(7'b0110011, 3'b100, 1'b0, 1'b0);
    chk("xor_ALUControl", {1'b0, ALUControl}, 4'd4);
    apply(7'b0110011, 3'b010, 1'b0, 1'b0);
    chk("slt_ALUControl", {1'b0, ALUControl}, 4'd5);
    apply(7'b0110011, 3'b101, 1'b1, 1'b0);
    chk("unsup_ALUControl", {1'b0, ALUControl}, 4'd0);
    apply(7'b1111111, 3'b000, 1'b1, 1'b1);
    chk("ill_RegWrite", {3'b0, RegWrite}, 4'd0);
    chk("ill_MemWrite", {3'b0, MemWrite}, 4'd0);
    chk("ill_PCSrc", {3'b0, PCSrc}, 4'd0);
`ifdef CTRL_ILLEGAL_OP_EN
    @(posedge clk);
    #2;
    chk("ill_flag_set", {3'b0, IllegalOp}, 4'd1);
    op = 7'b0000011;
    @(posedge clk);
    #2;
    chk("ill_flag_sticky", {3'b0, IllegalOp}, 4'd1);
    rst = 1'b1;
    op = 7'b1111111;
    @(posedge clk);
    #2;
    chk("ill_flag_rst_wins", {3'b0, IllegalOp}, 4'd0);
    rst = 1'b0;
    op = 7'b0000011;
`endif

    // Randomized stimulus; rst pulses occasionally to exercise the flag.
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] o;
      case ($urandom_range(0, 7))
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b0110011;
        3: o = 7'b0010011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        default: o = 7'($urandom);
      endcase
      @(posedge clk);
      #1;
      op = o;
      funct3 = 3'($urandom);
      funct7 = 1'($urandom);
      Zero = 1'($urandom);
      rst = ($urandom_range(0, 49) == 0);
    end

    @(posedge clk);
    #6;
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv_main_ctrl.md
Name: rv_main_ctrl

Overview:
- Control unit of the single-cycle RV32I core.
- Decodes opcode, funct3, funct7[5] and the ALU Zero flag into datapath controls: PC select, memory write, ALU operand select, register write, immediate format, result mux select and ALU operation.
- The two-level decode (main decoder plus ALU decoder) is purely combinational.
- clk/rst clock only the optional illegal-opcode flag.

Parameters:
- None.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset; affects only registered state, never the combinational decode
- op  in  7  instruction opcode, instr[6:0]
- funct3  in  3  instr[14:12]
- funct7  in  1  instr[30], i.e. funct7 bit 5
- Zero  in  1  ALU result-equals-zero flag
- PCSrc  out  1  1 = PC <- PC+imm, 0 = PC+4
- MemWrite  out  1  data memory write enable
- ALUSrc  out  1  1 = immediate operand B, 0 = register rs2
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
- ResultSrc  out  2  00 ALU result, 01 memory read data, 10 PC+4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt

Behaviour:
- All outputs except the optional flag are combinational functions of op, funct3, funct7 and Zero. They settle within the same cycle, have zero latency and are unaffected by rst.
- Main decoder, fields listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump:
  - 0000011 lw: 1, 00, 1, 0, 01, 0, 00, 0
  - 0100011 sw: 0, 01, 1, 1, 00, 0, 00, 0
  - 0110011 R-type: 1, 00, 0, 0, 00, 0, 10, 0
  - 0010011 I-type ALU: 1, 00, 1, 0, 00, 0, 10, 0
  - 1100011 beq: 0, 10, 0, 0, 00, 1, 01, 0
  - 1101111 jal: 1, 11, 0, 0, 10, 0, 00, 1
  - any other op: all fields 0 (no register write, no memory write, no PC redirect)
- Branch, Jump and ALUOp are internal signals.
- PCSrc = (Branch AND Zero) OR Jump.
  - jal redirects regardless of Zero.
  - beq redirects only when Zero=1.
- ALU decoder:
  - ALUOp 00 -> 000 (add, used for address generation)
  - ALUOp 01 -> 001 (sub, used for compare)
  - ALUOp 10, by funct3:
    - 000 -> 001 only when op[5]=1 AND funct7=1 (R-type sub); otherwise 000. addi is always add whatever funct7 is.
    - 010 -> 101 slt
    - 100 -> 100 xor
    - 110 -> 011 or
    - 111 -> 010 and
    - 001, 011, 101 (unsupported) -> 000
  - ALUOp 11 does not occur; it maps to 000.
- Outputs are never X/Z for any fully driven input combination.

Optional Feature:
- Macro CTRL_ILLEGAL_OP_EN.
- When defined, output port IllegalOp (1 bit, registered) is added:
  - On each rising clk edge: if rst=1, IllegalOp <= 0.
  - Otherwise, IllegalOp <= IllegalOp OR (op not in {0000011, 0100011, 0110011, 0010011, 1100011, 1101111}).
  - The flag is sticky until reset. It is set on the edge following the first cycle an illegal op is present. Reset wins over a simultaneous illegal op.
- When not defined:
  - The port and register are absent.
  - Illegal opcodes only produce the all-zero decode above.
  - clk and rst are unused.

Test Plan:
- op=0000011, Zero=0 -> RegWrite=1, ImmSrc=00, ALUSrc=1, MemWrite=0, ResultSrc=01, PCSrc=0, ALUControl=000.
- op=0100011, Zero=0 -> RegWrite=0, ImmSrc=01, ALUSrc=1, MemWrite=1, PCSrc=0.
- op=0010011, funct3=000, funct7=1 -> RegWrite=1, ImmSrc=00, ALUSrc=1, MemWrite=0, ResultSrc=00, ALUControl=000 (no sub for addi). Same with op=0110011 -> ALUControl=001, ALUSrc=0.
- op=1101111, Zero=0 -> RegWrite=1, ImmSrc=11, MemWrite=0, ResultSrc=10, PCSrc=1.
- op=1100011: Zero=1 -> RegWrite=0, ImmSrc=10, ALUSrc=0, MemWrite=0, ALUControl=001, PCSrc=1; Zero=0 -> PCSrc=0.
- R-type funct3 sweep 111/110/100/010 -> ALUControl 010/011/100/101.
- op=1111111 -> RegWrite=MemWrite=PCSrc=0.
- With CTRL_ILLEGAL_OP_EN: IllegalOp=1 one edge after op=1111111, stays 1 after op returns to lw, and clears on the edge where rst=1.
